// File: rtl/noc_flit_pkg.sv
// noc_flit_pkg: flit type codes, field layout helpers and per-VC state shared by NoC endpoints.
package noc_flit_pkg;
    localparam int HEAD_TAIL = 2;
    localparam logic [HEAD_TAIL-1:0] HEAD_FLIT = 2'b01;
    localparam logic [HEAD_TAIL-1:0] BODY_FLIT = 2'b10;
    localparam logic [HEAD_TAIL-1:0] TAIL_FLIT = 2'b00;
    localparam logic [HEAD_TAIL-1:0] HEADER    = 2'b11;
    localparam int DEF_VC_WIDTH      = 1;
    localparam int DEF_DATA_WIDTH    = 16;
    localparam int FLIT_TOTAL_WIDTH  = HEAD_TAIL + DEF_VC_WIDTH + DEF_DATA_WIDTH;

    function automatic int flit_total_width(input int vc_w, input int data_w);
        return HEAD_TAIL + vc_w + data_w;
    endfunction

    // Layout from MSB: type, VC, data.
    function automatic int vc_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int type_lsb(input int vc_w, input int data_w);
        return vc_w + data_w;
    endfunction

    typedef enum logic {VC_IDLE, VC_ACTIVE} vc_state_e;
endpackage

// File: rtl/flit_sink_vc_ctx.sv
// flit_sink_vc_ctx: reassembly context for one virtual channel; reports the completed
// descriptor combinationally in the cycle its closing flit is accepted.
module flit_sink_vc_ctx
    import noc_flit_pkg::*;
#(
    parameter int NODE_ID         = 0,
    parameter int DEST_NODE_WIDTH = 3,
    parameter int FLIT_DATA_WIDTH = 16,
    parameter int LEN_WIDTH       = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [HEAD_TAIL-1:0]       ftype,
    input  logic [FLIT_DATA_WIDTH-1:0] data,
    output logic                       done,
    output logic                       misroute,
    output logic                       proto,
    output logic [DEST_NODE_WIDTH-1:0] d_src,
    output logic [LEN_WIDTH-1:0]       d_len,
    output logic [FLIT_DATA_WIDTH-1:0] d_sum,
    output logic                       d_err
);
    vc_state_e state, state_n;
    logic [DEST_NODE_WIDTH-1:0] src, f_src, f_dest;
    logic [LEN_WIDTH-1:0]       len, len_n;
    logic [FLIT_DATA_WIDTH-1:0] sum, sum_n;
    logic                       err, err_n, is_start, mis_raw, sat;

    always_comb begin
        f_dest   = data[FLIT_DATA_WIDTH-1 -: DEST_NODE_WIDTH];
        f_src    = data[FLIT_DATA_WIDTH-1-DEST_NODE_WIDTH -: DEST_NODE_WIDTH];
        is_start = ftype == HEAD_FLIT || ftype == HEADER;
        mis_raw  = f_dest != DEST_NODE_WIDTH'(NODE_ID);
        misroute = en && is_start && mis_raw;
        proto    = en && (state == VC_ACTIVE ? is_start : !is_start);
        sat      = &len;
        len_n    = sat ? len : len + 1'b1;
        sum_n    = sum ^ data;
        err_n    = err | sat;
        done     = en && (ftype == HEADER || (state == VC_ACTIVE && ftype == TAIL_FLIT));
        state_n  = !en ? state : ftype == HEAD_FLIT ? VC_ACTIVE :
                   (ftype == BODY_FLIT) ? state : VC_IDLE;
        d_src    = ftype == HEADER ? f_src : src;
        d_len    = ftype == HEADER ? LEN_WIDTH'(1) : len_n;
        d_sum    = ftype == HEADER ? '0 : sum_n;
        d_err    = ftype == HEADER ? mis_raw : err_n;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= VC_IDLE;
        else       state <= state_n;
    end

    // A HEAD restarts the context even mid-packet, discarding the partial one.
    always_ff @(posedge clk) begin
        if (reset) begin
            src <= '0;
            len <= '0;
            sum <= '0;
            err <= 1'b0;
        end else if (en && ftype == HEAD_FLIT) begin
            src <= f_src;
            len <= LEN_WIDTH'(1);
            sum <= '0;
            err <= mis_raw;
        end else if (en && ftype == BODY_FLIT && state == VC_ACTIVE) begin
            len <= len_n;
            sum <= sum_n;
            err <= err_n;
        end
    end
endmodule

// File: rtl/flit_sink.sv
// flit_sink: local ejection endpoint reassembling flits into per-VC packet descriptors.
// Define FLIT_SINK_STATS_EN to add the stat_pkts/stat_flits/stat_errs counters.
module flit_sink
    import noc_flit_pkg::*;
#(
    parameter int NUM_OF_NODES            = 8,
    parameter int FLIT_DATA_WIDTH         = 16,
    parameter int NUM_OF_VIRTUAL_CHANNELS = 2,
    parameter int NODE_ID                 = 0,
    parameter int LEN_WIDTH               = 8,
    localparam int DEST_NODE_WIDTH        = $clog2(NUM_OF_NODES),
    localparam int VC_WIDTH               = $clog2(NUM_OF_VIRTUAL_CHANNELS),
    localparam int FLIT_W                 = flit_total_width(VC_WIDTH, FLIT_DATA_WIDTH)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [FLIT_W-1:0]                  flit_in,
    input  logic                               flit_valid,
    output logic                               flit_ready,
    output logic [NUM_OF_VIRTUAL_CHANNELS-1:0] credit_out,
    output logic                               pkt_valid,
    input  logic                               pkt_ready,
    output logic [DEST_NODE_WIDTH-1:0]         pkt_src,
    output logic [VC_WIDTH-1:0]                pkt_vc,
    output logic [LEN_WIDTH-1:0]               pkt_len,
    output logic [FLIT_DATA_WIDTH-1:0]         pkt_sum,
    output logic                               pkt_err,
    output logic                               err_misroute,
    output logic                               err_proto
`ifdef FLIT_SINK_STATS_EN
    ,
    output logic [31:0]                        stat_pkts,
    output logic [31:0]                        stat_flits,
    output logic [31:0]                        stat_errs
`endif
);
    localparam int NVC = NUM_OF_VIRTUAL_CHANNELS;

    logic [HEAD_TAIL-1:0]       ftype;
    logic [VC_WIDTH-1:0]        vc;
    logic [FLIT_DATA_WIDTH-1:0] data;
    logic                       accept;
    logic [NVC-1:0]             done_v, mis_v, proto_v;
    logic [DEST_NODE_WIDTH-1:0] d_src [NVC];
    logic [LEN_WIDTH-1:0]       d_len [NVC];
    logic [FLIT_DATA_WIDTH-1:0] d_sum [NVC];
    logic [NVC-1:0]             d_err;

    always_comb begin
        ftype      = flit_in[type_lsb(VC_WIDTH, FLIT_DATA_WIDTH) +: HEAD_TAIL];
        vc         = flit_in[vc_lsb(FLIT_DATA_WIDTH) +: VC_WIDTH];
        data       = flit_in[FLIT_DATA_WIDTH-1:0];
        flit_ready = !(pkt_valid && !pkt_ready);
        accept     = flit_valid && flit_ready;
    end

    for (genvar i = 0; i < NVC; i++) begin : g_vc
        flit_sink_vc_ctx #(
            .NODE_ID(NODE_ID),
            .DEST_NODE_WIDTH(DEST_NODE_WIDTH),
            .FLIT_DATA_WIDTH(FLIT_DATA_WIDTH),
            .LEN_WIDTH(LEN_WIDTH)
        ) u_ctx (
            .clk(clk),
            .reset(reset),
            .en(accept && vc == VC_WIDTH'(i)),
            .ftype(ftype),
            .data(data),
            .done(done_v[i]),
            .misroute(mis_v[i]),
            .proto(proto_v[i]),
            .d_src(d_src[i]),
            .d_len(d_len[i]),
            .d_sum(d_sum[i]),
            .d_err(d_err[i])
        );
    end

    // A completion can only arrive while the slot is free or being drained this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            credit_out   <= '0;
            err_misroute <= 1'b0;
            err_proto    <= 1'b0;
            pkt_valid    <= 1'b0;
            pkt_src      <= '0;
            pkt_vc       <= '0;
            pkt_len      <= '0;
            pkt_sum      <= '0;
            pkt_err      <= 1'b0;
        end else begin
            credit_out   <= accept ? NVC'(1) << vc : '0;
            err_misroute <= |mis_v;
            err_proto    <= |proto_v;
            if (|done_v) begin
                pkt_valid <= 1'b1;
                pkt_src   <= d_src[vc];
                pkt_vc    <= vc;
                pkt_len   <= d_len[vc];
                pkt_sum   <= d_sum[vc];
                pkt_err   <= d_err[vc];
            end else if (pkt_ready) begin
                pkt_valid <= 1'b0;
            end
        end
    end

`ifdef FLIT_SINK_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_pkts  <= '0;
            stat_flits <= '0;
            stat_errs  <= '0;
        end else begin
            stat_pkts  <= stat_pkts + 32'(|done_v);
            stat_flits <= stat_flits + 32'(accept);
            stat_errs  <= stat_errs + 32'(err_misroute) + 32'(err_proto);
        end
    end
`endif
endmodule

// File: tb/tb_flit_sink.sv
// tb_flit_sink: directed stimulus with expected descriptors, credits and error pulses
// queued at issue time and checked by an independent output monitor.
module tb_flit_sink;
    import noc_flit_pkg::*;

    typedef struct packed {
        logic [2:0]  src;
        logic        vc;
        logic [7:0]  len;
        logic [15:0] sum;
        logic        err;
    } desc_t;

    logic        clk = 1'b0, reset = 1'b1;
    logic [18:0] flit_in = '0;
    logic        flit_valid = 1'b0, pkt_ready = 1'b1;
    logic        flit_ready, pkt_valid, pkt_err, err_misroute, err_proto, pkt_vc;
    logic [1:0]  credit_out;
    logic [2:0]  pkt_src;
    logic [7:0]  pkt_len;
    logic [15:0] pkt_sum;
`ifdef FLIT_SINK_STATS_EN
    logic [31:0] stat_pkts, stat_flits, stat_errs;
`endif

    desc_t      desc_q[$];
    logic [1:0] credit_q[$];
    logic [1:0] errev_q[$];
    desc_t      exp_d;
    logic [1:0] exp_c, exp_e;
    int         checks = 0, failures = 0;

    flit_sink #(.NODE_ID(1)) dut (
        .clk(clk), .reset(reset), .flit_in(flit_in), .flit_valid(flit_valid),
        .flit_ready(flit_ready), .credit_out(credit_out), .pkt_valid(pkt_valid),
        .pkt_ready(pkt_ready), .pkt_src(pkt_src), .pkt_vc(pkt_vc), .pkt_len(pkt_len),
        .pkt_sum(pkt_sum), .pkt_err(pkt_err), .err_misroute(err_misroute),
        .err_proto(err_proto)
`ifdef FLIT_SINK_STATS_EN
        , .stat_pkts(stat_pkts), .stat_flits(stat_flits), .stat_errs(stat_errs)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [18:0] mk(input logic [1:0] t, input logic v, input logic [15:0] d);
        return {t, v, d};
    endfunction

    function automatic logic [15:0] hd(input logic [2:0] dest, input logic [2:0] src);
        return {dest, src, 10'h0};
    endfunction

    // ev = {misroute, proto} expected for this flit.
    task automatic send(input logic [18:0] f, input logic [1:0] ev);
        int n = 0;
        credit_q.push_back(2'b01 << f[16]);
        if (ev != 2'b00) errev_q.push_back(ev);
        @(negedge clk);
        flit_in = f;
        flit_valid = 1'b1;
        while (!flit_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", 32'(flit_ready), 1);
        @(posedge clk);
        #1 flit_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (pkt_valid === 1'b1 && pkt_ready) begin
            if (desc_q.size() == 0) chk("unexpected_desc", 1, 0);
            else begin
                exp_d = desc_q.pop_front();
                chk("desc", 32'({pkt_src, pkt_vc, pkt_len, pkt_sum, pkt_err}), 32'(exp_d));
            end
        end
        if (credit_out !== 2'b00) begin
            if (credit_q.size() == 0) chk("unexpected_credit", 32'(credit_out), 0);
            else begin
                exp_c = credit_q.pop_front();
                chk("credit", 32'(credit_out), 32'(exp_c));
            end
        end
        if (err_misroute !== 1'b0 || err_proto !== 1'b0) begin
            if (errev_q.size() == 0) chk("unexpected_err", 32'({err_misroute, err_proto}), 0);
            else begin
                exp_e = errev_q.pop_front();
                chk("err_pulse", 32'({err_misroute, err_proto}), 32'(exp_e));
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_flit_ready", 32'(flit_ready), 1);
        chk("rst_credit", 32'(credit_out), 0);
        chk("rst_pkt_valid", 32'(pkt_valid), 0);
        chk("rst_fields", 32'({pkt_src, pkt_vc, pkt_len, pkt_sum, pkt_err}), 0);
        chk("rst_errs", 32'({err_misroute, err_proto}), 0);

        desc_q.push_back('{src: 3'd0, vc: 1'b0, len: 8'd1, sum: 16'h0, err: 1'b0});
        send(19'h62000, 2'b00);
        chk("hdr_valid_next", 32'(pkt_valid), 1);
        chk("hdr_credit_next", 32'(credit_out), 1);

        send(mk(HEAD_FLIT, 1'b1, hd(3'd1, 3'd3)), 2'b00);
        send(mk(BODY_FLIT, 1'b1, 16'h00F0), 2'b00);
        desc_q.push_back('{src: 3'd3, vc: 1'b1, len: 8'd3, sum: 16'h0FFF, err: 1'b0});
        send(mk(TAIL_FLIT, 1'b1, 16'h0F0F), 2'b00);

        desc_q.push_back('{src: 3'd5, vc: 1'b0, len: 8'd1, sum: 16'h0, err: 1'b1});
        send(mk(HEADER, 1'b0, hd(3'd2, 3'd5)), 2'b10);
        chk("misroute_pulse", 32'(err_misroute), 1);

        send(mk(BODY_FLIT, 1'b0, 16'h1111), 2'b01);
        chk("idle_body_proto", 32'(err_proto), 1);
        chk("idle_body_no_desc", 32'(pkt_valid), 0);

        send(mk(HEAD_FLIT, 1'b0, hd(3'd1, 3'd2)), 2'b00);
        send(mk(HEAD_FLIT, 1'b1, hd(3'd1, 3'd4)), 2'b00);
        send(mk(BODY_FLIT, 1'b1, 16'h1234), 2'b00);
        desc_q.push_back('{src: 3'd2, vc: 1'b0, len: 8'd2, sum: 16'h00AA, err: 1'b0});
        send(mk(TAIL_FLIT, 1'b0, 16'h00AA), 2'b00);
        desc_q.push_back('{src: 3'd4, vc: 1'b1, len: 8'd3, sum: 16'h1225, err: 1'b0});
        send(mk(TAIL_FLIT, 1'b1, 16'h0011), 2'b00);

        send(mk(HEAD_FLIT, 1'b0, hd(3'd1, 3'd1)), 2'b00);
        desc_q.push_back('{src: 3'd7, vc: 1'b0, len: 8'd1, sum: 16'h0, err: 1'b0});
        send(mk(HEADER, 1'b0, hd(3'd1, 3'd7)), 2'b01);

        @(posedge clk);
        #1 pkt_ready = 1'b0;
        desc_q.push_back('{src: 3'd2, vc: 1'b1, len: 8'd1, sum: 16'h0, err: 1'b0});
        send(mk(HEADER, 1'b1, hd(3'd1, 3'd2)), 2'b00);
        desc_q.push_back('{src: 3'd3, vc: 1'b0, len: 8'd1, sum: 16'h0, err: 1'b0});
        fork
            send(mk(HEADER, 1'b0, hd(3'd1, 3'd3)), 2'b00);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_flit_ready", 32'(flit_ready), 0);
                    chk("bp_hold_src", 32'(pkt_src), 2);
                end
                @(posedge clk);
                #1 pkt_ready = 1'b1;
            end
        join

        send(mk(HEAD_FLIT, 1'b1, hd(3'd1, 3'd4)), 2'b00);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        send(mk(TAIL_FLIT, 1'b1, 16'h5555), 2'b01);

        repeat (5) @(negedge clk);
        chk("desc_q_empty", 32'(desc_q.size()), 0);
        chk("credit_q_empty", 32'(credit_q.size()), 0);
        chk("err_q_empty", 32'(errev_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
